garage_door_plant: RTL and testbench
====================================

Name: garage_door_plant

Overview:
- Behavioural plant model of the door and its limit switches: the other end of the garage door controller's motor interface.
- Consumes the controller's motor commands UP_M/DN_M, integrates door position over time, and drives the UP_Max/DN_Max limit-switch inputs back to the controller.
- Used for closed-loop simulation and for FPGA demo builds where no physical door exists.
- Also flags illegal motor command combinations.

Parameters:
- TRAVEL_STEPS, 16: position count from fully closed (0) to fully open (TRAVEL_STEPS).
- STEP_DIV, 4: clock cycles of continuous motor drive per one position step.
- POS_W, 5: width of the position output; must hold TRAVEL_STEPS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- UP_M  in  1  open-motor command from controller.
- DN_M  in  1  close-motor command from controller.
- UP_Max  out  1  door fully open limit switch.
- DN_Max  out  1  door fully closed limit switch.
- position  out  POS_W  current door position, 0 = closed.
- moving  out  1  position prescaler is actively counting.
- fault  out  1  sticky illegal-command flag.

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-high. While rst=1, outputs are forced immediately:
  - position=0, prescaler=0, state=CLOSED
  - DN_Max=1, UP_Max=0, moving=0, fault=0
- Limit switches are decoded directly from the position register, with no added latency:
  - DN_Max = (position==0)
  - UP_Max = (position==TRAVEL_STEPS)
- States: CLOSED, OPENING, OPEN, CLOSING, HALTED (stopped mid-travel), FAULT.
- Command decode, sampled every rising edge:
  - UP only = drive up; DN only = drive down; neither = idle; both = illegal.
- Transitions:
  - Any state except FAULT, illegal command -> FAULT on that edge. fault=1, position frozen, prescaler cleared. FAULT exits only via rst.
  - Drive up while position<TRAVEL_STEPS -> OPENING.
  - Drive down while position>0 -> CLOSING.
  - Idle with 0<position<TRAVEL_STEPS -> HALTED.
  - position==0 -> CLOSED; position==TRAVEL_STEPS -> OPEN.
- Stepping:
  - In OPENING/CLOSING the prescaler increments each edge.
  - On the edge where prescaler==STEP_DIV-1: prescaler clears and position moves ±1.
  - Position therefore changes on the STEP_DIV-th consecutive edge of drive.
- Any cycle without drive, or a direction reversal, clears the prescaler. Partial steps are discarded; the reversal cycle counts as the first cycle of the new direction.
- Saturation:
  - Drive up at TRAVEL_STEPS, or drive down at 0: position holds, prescaler stays 0, moving=0, no fault.
  - Holding the motor against the limit is legal.
- moving=1 exactly when state is OPENING or CLOSING and the prescaler is counting.
- Full travel takes TRAVEL_STEPS*STEP_DIV cycles (64 at defaults).
- Reset mid-travel: position returns to 0 asynchronously. The model does not retain physical position across reset.

Decomposition:
- Package garage_door_pkg holds:
  - the door state enum
  - default TRAVEL_STEPS/STEP_DIV constants
  - the motor command encoding
- The controller and this plant share this package.
- One sub-module, step_prescaler: counts up to STEP_DIV-1 with clear and enable, and emits a one-cycle step pulse.

Test Plan:
- Reset with defaults: rst pulse -> position=0, DN_Max=1, UP_Max=0, fault=0, moving=0. Outputs valid before the first clock edge.
- UP_M=1 held from cycle 0:
  - edge 4 -> position=1, DN_Max=0
  - edge 64 -> position=16, UP_Max=1
  - edges 65-80 -> position stays 16, moving=0
- Stop mid-travel: UP_M=1 for 10 edges (position=2), UP_M=0 for 1 edge (HALTED, prescaler cleared), UP_M=1 again -> position=3 exactly 4 edges later, not 2.
- Reversal from position=8: DN_M replaces UP_M with the prescaler at 2 -> position=7 four edges after the switch; DN_Max=1 when position reaches 0.
- Illegal command at position=5: UP_M=DN_M=1 for 1 edge -> fault=1 that edge. Then a valid UP_M for 20 edges -> position stays 5, fault stays 1; cleared only by rst.
- Asynchronous reset at position=9 while OPENING: rst asserted mid-cycle -> position=0 and DN_Max=1 immediately. After release, UP_M=1 -> position=1 on the 4th edge.

Source files
------------

// File: rtl/garage_door_pkg.sv
// Shared definitions for the garage door controller and its plant model:
// door states, default travel geometry and the motor command encoding.
package garage_door_pkg;

    localparam int TRAVEL_STEPS_DEF = 16;
    localparam int STEP_DIV_DEF     = 4;

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_HALTED,
        ST_FAULT
    } door_state_t;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'b00,
        CMD_DOWN    = 2'b01,
        CMD_UP      = 2'b10,
        CMD_ILLEGAL = 2'b11
    } motor_cmd_t;

    function automatic motor_cmd_t decode_cmd(input logic up, input logic dn);
        return motor_cmd_t'({up, dn});
    endfunction

endpackage

// File: rtl/garage_door_plant_step_prescaler.sv
// Drive-time prescaler: counts enabled cycles up to DIV-1 and emits a
// one-cycle step pulse on the wrapping cycle.
module step_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic step
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] base;

    // restart discards the partial count but still counts this cycle
    always_comb begin
        base = restart ? '0 : count;
        step = enable && (base == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!enable || step) begin
            count <= '0;
        end else begin
            count <= base + CW'(1);
        end
    end

endmodule

// File: rtl/garage_door_plant.sv
// Behavioural door plant: integrates motor drive into a position and
// reports limit switches and illegal command combinations.
module garage_door_plant
    import garage_door_pkg::*;
#(
    parameter int TRAVEL_STEPS = TRAVEL_STEPS_DEF,
    parameter int STEP_DIV     = STEP_DIV_DEF,
    parameter int POS_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UP_M,
    input  logic             DN_M,
    output logic             UP_Max,
    output logic             DN_Max,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             fault
);

    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(TRAVEL_STEPS);
    localparam logic [POS_W-1:0] POS_NEAR = POS_W'(TRAVEL_STEPS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    door_state_t      state;
    door_state_t      state_n;
    logic [POS_W-1:0] pos_n;
    motor_cmd_t       cmd;
    logic             drive_up;
    logic             drive_dn;
    logic             enable;
    logic             restart;
    logic             step;

    assign cmd = decode_cmd(UP_M, DN_M);

    // Drive only counts when it can actually move the door
    assign drive_up = (state != ST_FAULT) && (cmd == CMD_UP)
                      && (position != POS_TOP);
    assign drive_dn = (state != ST_FAULT) && (cmd == CMD_DOWN)
                      && (position != '0);
    assign enable   = drive_up || drive_dn;
    assign restart  = (drive_up && state == ST_CLOSING)
                      || (drive_dn && state == ST_OPENING);

    step_prescaler #(
        .DIV(STEP_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .restart(restart),
        .step   (step)
    );

    always_comb begin
        state_n = state;
        pos_n   = position;
        if (state != ST_FAULT) begin
            unique case (cmd)
                CMD_ILLEGAL: begin
                    state_n = ST_FAULT;
                end
                CMD_UP: begin
                    if (drive_up) begin
                        if (step) begin
                            pos_n = position + POS_ONE;
                        end
                        state_n = (step && position == POS_NEAR)
                                  ? ST_OPEN : ST_OPENING;
                    end else begin
                        state_n = ST_OPEN;
                    end
                end
                CMD_DOWN: begin
                    if (drive_dn) begin
                        if (step) begin
                            pos_n = position - POS_ONE;
                        end
                        state_n = (step && position == POS_ONE)
                                  ? ST_CLOSED : ST_CLOSING;
                    end else begin
                        state_n = ST_CLOSED;
                    end
                end
                default: begin
                    if (position == '0) begin
                        state_n = ST_CLOSED;
                    end else if (position == POS_TOP) begin
                        state_n = ST_OPEN;
                    end else begin
                        state_n = ST_HALTED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLOSED;
            position <= '0;
        end else begin
            state    <= state_n;
            position <= pos_n;
        end
    end

    assign DN_Max = (position == '0);
    assign UP_Max = (position == POS_TOP);
    assign moving = (state == ST_OPENING) || (state == ST_CLOSING);
    assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_garage_door_plant.sv
// Scoreboarded bench for garage_door_plant against a cycle model of
// door travel, limit switches and the sticky fault flag.
module tb_garage_door_plant;

    localparam int TS  = 16;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       UP_M;
    logic       DN_M;
    logic       UP_Max;
    logic       DN_Max;
    logic [4:0] position;
    logic       moving;
    logic       fault;

    typedef struct packed {
        logic [4:0] pos;
        logic       up_max;
        logic       dn_max;
        logic       mov;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int m_pos;
    int m_cnt;
    int m_dir;
    bit m_fault;

    garage_door_plant dut (
        .clk     (clk),
        .rst     (rst),
        .UP_M    (UP_M),
        .DN_M    (DN_M),
        .UP_Max  (UP_Max),
        .DN_Max  (DN_Max),
        .position(position),
        .moving  (moving),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_pos   = 0;
        m_cnt   = 0;
        m_dir   = 0;
        m_fault = 0;
    endtask

    task automatic model_step(input logic up, input logic dn);
        if (m_fault) begin
        end else if (up && dn) begin
            m_fault = 1;
            m_cnt   = 0;
            m_dir   = 0;
        end else if (up && m_pos < TS) begin
            if (m_dir != 1) m_cnt = 0;
            m_cnt++;
            if (m_cnt == DIV) begin
                m_pos++;
                m_cnt = 0;
            end
            m_dir = 1;
        end else if (dn && m_pos > 0) begin
            if (m_dir != 2) m_cnt = 0;
            m_cnt++;
            if (m_cnt == DIV) begin
                m_pos--;
                m_cnt = 0;
            end
            m_dir = 2;
        end else begin
            m_cnt = 0;
            m_dir = 0;
        end
    endtask

    task automatic cyc(input logic up, input logic dn);
        exp_t e;
        exp_t got;
        UP_M = up;
        DN_M = dn;
        model_step(up, dn);
        e.pos    = 5'(m_pos);
        e.up_max = (m_pos == TS);
        e.dn_max = (m_pos == 0);
        e.mov    = !m_fault && ((up && !dn && m_pos < TS)
                                || (dn && !up && m_pos > 0));
        e.flt    = m_fault;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {position, UP_Max, DN_Max, moving, fault};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got pos=%0d up=%b dn=%b mov=%b flt=%b want pos=%0d up=%b dn=%b mov=%b flt=%b",
                     $time, got.pos, got.up_max, got.dn_max, got.mov, got.flt,
                     e.pos, e.up_max, e.dn_max, e.mov, e.flt);
        end
    endtask

    task automatic do_reset();
        UP_M = 1'b0;
        DN_M = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        UP_M = 1'b0;
        DN_M = 1'b0;
        rst  = 1'b1;
        #2;
        checks++;
        if ({position, DN_Max, UP_Max, fault, moving} !== {5'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_state got pos=%0d dn=%b up=%b flt=%b mov=%b want 0 1 0 0 0",
                     position, DN_Max, UP_Max, fault, moving);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_open_full();
        do_reset();
        for (int i = 1; i <= 80; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 4) begin
                checks++;
                if (position !== 5'd1 || DN_Max !== 1'b0) begin
                    errors++;
                    $display("FAIL first_step got pos=%0d dn=%b want 1 0", position, DN_Max);
                end
            end
            if (i == 64) begin
                checks++;
                if (position !== 5'd16 || UP_Max !== 1'b1) begin
                    errors++;
                    $display("FAIL full_open got pos=%0d up=%b want 16 1", position, UP_Max);
                end
            end
            if (i == 80) begin
                checks++;
                if (position !== 5'd16 || moving !== 1'b0 || fault !== 1'b0) begin
                    errors++;
                    $display("FAIL saturate got pos=%0d mov=%b flt=%b want 16 0 0",
                             position, moving, fault);
                end
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 2 || i == 3) begin
                checks++;
                if (position !== 5'd2) begin
                    errors++;
                    $display("FAIL halt_partial i=%0d got pos=%0d want 2", i, position);
                end
            end
        end
        checks++;
        if (position !== 5'd3) begin
            errors++;
            $display("FAIL halt_resume got pos=%0d want 3", position);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        for (int i = 0; i < 34; i++) cyc(1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1);
        checks++;
        if (position !== 5'd7) begin
            errors++;
            $display("FAIL reversal got pos=%0d want 7", position);
        end
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1);
        checks++;
        if (position !== 5'd0 || DN_Max !== 1'b1 || moving !== 1'b0) begin
            errors++;
            $display("FAIL closed got pos=%0d dn=%b mov=%b want 0 1 0",
                     position, DN_Max, moving);
        end
    endtask

    task automatic test_fault();
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        checks++;
        if (fault !== 1'b1 || position !== 5'd5) begin
            errors++;
            $display("FAIL fault_set got flt=%b pos=%0d want 1 5", fault, position);
        end
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        checks++;
        if (fault !== 1'b1 || position !== 5'd5 || moving !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky got flt=%b pos=%0d mov=%b want 1 5 0",
                     fault, position, moving);
        end
        do_reset();
        checks++;
        if (fault !== 1'b0 || position !== 5'd0) begin
            errors++;
            $display("FAIL fault_clear got flt=%b pos=%0d want 0 0", fault, position);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 36; i++) cyc(1'b1, 1'b0);
        checks++;
        if (position !== 5'd9 || moving !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got pos=%0d mov=%b want 9 1", position, moving);
        end
        #3;
        UP_M = 1'b0;
        rst  = 1'b1;
        #1;
        checks++;
        if (position !== 5'd0 || DN_Max !== 1'b1 || moving !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pos=%0d dn=%b mov=%b want 0 1 0",
                     position, DN_Max, moving);
        end
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 3) begin
                checks++;
                if (position !== 5'd0) begin
                    errors++;
                    $display("FAIL post_reset_early got pos=%0d want 0", position);
                end
            end
        end
        checks++;
        if (position !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_step got pos=%0d want 1", position);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_open_full();
        test_halt();
        test_reversal();
        test_fault();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
